// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, wrap or saturate boundary mode,
// parallel load with clamping, clear, and terminal-count status outputs.
module updown_counter_mod #(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
   parameter bit          SATURATE  = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [WIDTH-1:0] q_o,
   output logic             at_zero_o,
   output logic             at_max_o,
   output logic             wrap_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

   if (WIDTH < 1 || MAX_COUNT == 0 || MAX_COUNT > (1 << WIDTH) - 1) begin : gen_param_check
      $error("updown_counter_mod: MAX_COUNT must be in 1 .. 2**WIDTH-1");
   end

   logic [WIDTH-1:0] q_d, q_q;
   logic             wrap_d, wrap_q;
   logic             ovf_d, ovf_q;

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (clr_i) begin
         q_d   = '0;
         ovf_d = 1'b0;
      end else if (load_i) begin
         q_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            if (q_q < MaxVal) begin
               q_d = q_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
               if (!SATURATE) begin
                  q_d    = '0;
                  wrap_d = 1'b1;
               end
            end
         end else begin
            if (q_q != '0) begin
               q_d = q_q - 1'b1;
            end else begin
               ovf_d = 1'b1;
               if (!SATURATE) begin
                  q_d    = MaxVal;
                  wrap_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign q_o       = q_q;
   assign wrap_o    = wrap_q;
   assign ovf_o     = ovf_q;
   assign at_zero_o = (q_q == '0);
   assign at_max_o  = (q_q == MaxVal);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Drives a wrapping and a saturating counter (WIDTH=3, MAX_COUNT=5) with the same
// stimulus and compares both against an arithmetic model of the counting rules.
module tb_updown_counter_mod;

   localparam int Max = 5;

   logic       clk = 1'b0;
   logic       rst_n, clr, load, en, up;
   logic [2:0] load_val;

   logic [2:0] q_w, q_s;
   logic       az_w, am_w, wr_w, ov_w;
   logic       az_s, am_s, wr_s, ov_s;

   int vectors = 0;
   int fails   = 0;

   // Model state: index 0 = wrap config, 1 = saturate config
   int m_q[2];
   int m_wrap[2];
   int m_ovf[2];

   always #5 clk = ~clk;

   updown_counter_mod #(.WIDTH(3), .MAX_COUNT(Max), .SATURATE(1'b0)) u_wrap (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
      .en_i(en), .up_i(up), .q_o(q_w), .at_zero_o(az_w), .at_max_o(am_w),
      .wrap_o(wr_w), .ovf_o(ov_w)
   );

   updown_counter_mod #(.WIDTH(3), .MAX_COUNT(Max), .SATURATE(1'b1)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(load_val),
      .en_i(en), .up_i(up), .q_o(q_s), .at_zero_o(az_s), .at_max_o(am_s),
      .wrap_o(wr_s), .ovf_o(ov_s)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input int i);
      int sat;
      sat = i;
      if (!rst_n || clr) begin
         m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
         m_q[i] = (int'(load_val) > Max) ? Max : int'(load_val);
         m_wrap[i] = 0;
      end else if (en) begin
         int nxt;
         nxt = up ? m_q[i] + 1 : m_q[i] - 1;
         m_wrap[i] = 0;
         if (nxt > Max || nxt < 0) begin
            m_ovf[i] = 1;
            if (sat == 0) begin
               m_q[i]    = (nxt > Max) ? 0 : Max;
               m_wrap[i] = 1;
            end
         end else begin
            m_q[i] = nxt;
         end
      end else begin
         m_wrap[i] = 0;
      end
   endtask

   task automatic step(input string tag, input logic rn, input logic c, input logic l,
                       input logic [2:0] lv, input logic e, input logic u);
      @(negedge clk);
      rst_n = rn; clr = c; load = l; load_val = lv; en = e; up = u;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk({tag, "/wrap.q"},       int'(q_w),  m_q[0]);
      chk({tag, "/wrap.at_zero"}, int'(az_w), int'(m_q[0] == 0));
      chk({tag, "/wrap.at_max"},  int'(am_w), int'(m_q[0] == Max));
      chk({tag, "/wrap.wrap"},    int'(wr_w), m_wrap[0]);
      chk({tag, "/wrap.ovf"},     int'(ov_w), m_ovf[0]);
      chk({tag, "/sat.q"},        int'(q_s),  m_q[1]);
      chk({tag, "/sat.at_zero"},  int'(az_s), int'(m_q[1] == 0));
      chk({tag, "/sat.at_max"},   int'(am_s), int'(m_q[1] == Max));
      chk({tag, "/sat.wrap"},     int'(wr_s), m_wrap[1]);
      chk({tag, "/sat.ovf"},      int'(ov_s), m_ovf[1]);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b0;
      foreach (m_q[i]) begin m_q[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; end

      // Reset held with conflicting controls active
      step("reset", 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      step("reset", 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);
      chk("reset_q_const", int'(q_w), 0);
      chk("reset_at_zero_const", int'(az_w), 1);

      // Count up 7 from zero: wrap DUT goes 1..5,0,1
      for (int k = 0; k < 7; k++) step("up7", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      chk("up7_wrap_q_const", int'(q_w), 1);
      chk("up7_sat_q_const", int'(q_s), 5);

      // From zero count down 2: wrap DUT goes 5 then 4
      step("clr", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      step("dn_wrap", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("dn_wrap_pulse_const", int'(wr_w), 1);
      step("dn2", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("dn2_q_const", int'(q_w), 4);

      // Saturation: up 8 then down 7 from a clean start
      step("clr2", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) step("sat_up", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      for (int k = 0; k < 7; k++) step("sat_dn", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("sat_dn_q_const", int'(q_s), 0);

      // Load clamp, then load beats count enable
      step("load7", 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
      chk("load7_q_const", int'(q_w), 5);
      step("load2_en", 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
      chk("load2_q_const", int'(q_w), 2);

      // Clear beats load and enable, with ovf set and q=4
      step("load4", 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
      step("clr_prio", 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b1);
      chk("clr_prio_ovf_const", int'(ov_w), 0);
      step("load2", 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
      step("up_to3", 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      step("rst_mid", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
      chk("rst_mid_q_const", int'(q_w), 0);

      // Randomised traffic
      for (int k = 0; k < 400; k++) begin
         logic rn, c, l, e, u;
         logic [2:0] lv;
         rn = ($urandom_range(0, 49) != 0);
         c  = ($urandom_range(0, 29) == 0);
         l  = ($urandom_range(0, 9) == 0);
         lv = 3'($urandom_range(0, 7));
         e  = ($urandom_range(0, 9) < 8);
         u  = ($urandom_range(0, 9) < 6);
         step("rand", rn, c, l, lv, e, u);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
